// File: rtl/dmem_bus_bridge_pkg.sv
// rtl/dmem_bus_bridge_pkg.sv - shared types and helpers for the data-memory bus bridge
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_t;

  localparam int unsigned WORD_OFF_W        = 2;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

  // Access size is recovered from how many lanes the decoder enabled.
  function automatic acc_size_t be_size(input logic [3:0] be);
    logic [2:0] cnt;
    cnt = 3'(be[0]) + 3'(be[1]) + 3'(be[2]) + 3'(be[3]);
    case (cnt)
      3'd1:    be_size = SZ_BYTE;
      3'd2:    be_size = SZ_HALF;
      3'd4:    be_size = SZ_WORD;
      default: be_size = SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_store_align.sv
// rtl/dmem_bus_bridge_store_align.sv - store data lane shifter and misalignment detector
module store_align
  import dmem_pkg::*;
(
  input  logic [WORD_OFF_W-1:0] addr_lo_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            be_i,
  output logic [31:0]           wdata_o,
  output logic                  misalign_o
);

  assign wdata_o = wdata_i << {addr_lo_i, 3'b000};

  always_comb begin
    misalign_o = 1'b0;
    case (be_size(be_i))
      SZ_WORD: misalign_o = |addr_lo_i;
      SZ_HALF: misalign_o = addr_lo_i[0];
      default: misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - MEM-stage bridge from pipeline load/store signals to a valid/ready data bus
module dmem_bus_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  byteEnable,
  output logic [31:0] RD_data,
  output logic        StallMem,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic        err_timeout,
  output logic        err_misalign
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tout_q, tout_d;
  logic              mis_q, mis_d;

  logic              access;
  logic [31:0]       wdata_aligned;
  logic              misalign;

  assign access = MemReadM | MemWriteM;

  store_align u_align (
    .addr_lo_i  (ALUResultM[WORD_OFF_W-1:0]),
    .wdata_i    (WriteDataM),
    .be_i       (byteEnable),
    .wdata_o    (wdata_aligned),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misalign) begin
            hold_d  = ERR_RDATA;
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            // A simultaneous read and write is issued as a write.
            we_d    = MemWriteM;
            addr_d  = {ALUResultM[31:2], 2'b00};
            be_d    = byteEnable;
            wdata_d = MemWriteM ? wdata_aligned : 32'h0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response in the final cycle still beats the timeout.
        if (rsp_valid) begin
          if (!we_q) hold_d = rsp_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          hold_d  = ERR_RDATA;
          tout_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      hold_q  <= 32'h0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
      mis_q   <= mis_d;
    end
  end

  // The IDLE stall is combinational, so it is gated to keep outputs low under reset.
  assign StallMem     = (state_q == IDLE) ? (access & reset)
                                          : ((state_q == REQ) || (state_q == WAIT));
  assign req_valid    = (state_q == REQ);
  assign req_we       = we_q;
  assign req_addr     = addr_q;
  assign req_wdata    = wdata_q;
  assign req_be       = be_q;
  assign RD_data      = hold_q;
  assign err_timeout  = tout_q;
  assign err_misalign = mis_q;

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- MEM-stage bridge between the pipeline's data-memory signals and a valid/ready data bus with variable response latency.
- Latches each load or store presented in the MEM stage, aligns store data to byte lanes, and issues one bus request per access.
- Asserts StallMem, which the hazard unit uses to freeze all stages, until the access completes.
- Returns the raw 32-bit read word on RD_data for the existing load extender.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before the access is aborted with an error.
- ERR_RDATA, 32'h0000_0000: RD_data value returned on a timeout or a misaligned access.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- ALUResultM  in  32  byte address
- WriteDataM  in  32  unshifted store data (rs2)
- byteEnable  in  4  lane mask already derived from funct3M and address
- RD_data  out  32  raw read word to the load extender
- StallMem  out  1  freeze request to the hazard unit
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_we  out  1  1 = write
- req_addr  out  32  word address ({ALUResultM[31:2],2'b00})
- req_wdata  out  32  lane-aligned store data
- req_be  out  4  byte strobes
- rsp_valid  in  1  bus response or write acknowledge
- rsp_rdata  in  32  read data
- err_timeout  out  1  sticky timeout flag
- err_misalign  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0; the data hold register is 0; the timeout counter is 0; err_timeout is cleared.
- Access definition: access = MemReadM | MemWriteM. When both are set, the access is treated as a write.
- Misaligned access: a word access with addr[1:0]≠0, or a half access with addr[0]=1. Byte-lane size is inferred from byteEnable popcount.
- IDLE:
  - StallMem = access.
  - On access and aligned: latch req_we, req_addr, req_be=byteEnable, req_wdata = WriteDataM << (8*addr[1:0]), then go to REQ.
  - On access and misaligned: no bus request; hold ← ERR_RDATA; pulse err_misalign; go to DONE.
  - rsp_valid is ignored in IDLE.
- REQ:
  - req_valid=1 and StallMem=1.
  - The latched request fields stay constant until req_ready.
  - On req_valid & req_ready, clear the counter and go to WAIT.
- WAIT:
  - StallMem=1 and the counter increments each cycle.
  - On rsp_valid: hold ← rsp_rdata (loads; unchanged for stores); go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 without rsp_valid: hold ← ERR_RDATA, set err_timeout, go to DONE.
  - If rsp_valid and timeout occur in the same cycle, rsp_valid wins.
- DONE:
  - StallMem=0 and RD_data=hold for exactly one cycle; the pipeline advances at this edge. Then go to IDLE.
  - DONE never starts a new request, which prevents re-issuing the completed access.
- RD_data equals hold in all states. Outside DONE the value is don't-care to the consumer but must be stable.
- Latency: an aligned access with ready=1 and a 1-cycle response occupies MEM for 4 cycles (IDLE, REQ, WAIT, DONE). A misaligned access occupies 2 cycles.
- Back-to-back accesses: the next access is detected in the IDLE cycle after DONE, with no bubble beyond that.
- Reset mid-transaction: any outstanding response is dropped and no request is reissued. The bus side must tolerate an orphan rsp_valid, which IDLE ignores.
- Reads issue req_be=byteEnable and req_wdata=0.

Decomposition:
- Package dmem_pkg:
  - state_t enum {IDLE, REQ, WAIT, DONE}.
  - Localparams for the word offset width and the default ERR_RDATA.
  - Function for byteEnable popcount/size decode.
- Sub-module store_align, combinational: computes the shifted wdata and the misalign flag from addr[1:0] and byteEnable.

Test Plan:
- lw at 0x100, rsp_rdata=0xCAFEBABE with 1-cycle latency and ready=1 → req_addr=0x100, req_we=0, StallMem high 3 cycles, RD_data=0xCAFEBABE in DONE.
- sb at 0x203 with WriteDataM=0x000000A5, byteEnable=4'b1000 → req_addr=0x200, req_wdata=0xA5000000, req_be=4'b1000, req_we=1; completes on ack.
- sh at 0x101 → no req_valid, err_misalign pulses once, RD_data=ERR_RDATA, StallMem high 1 cycle.
- ready held low 5 cycles, then rsp after 3 cycles → req fields stable throughout REQ; StallMem high 9 cycles; single request only.
- No response with TIMEOUT_CYCLES=8 → DONE after 8 WAIT cycles, err_timeout=1 and stays set until reset.
- reset asserted in WAIT, then rsp_valid arrives → outputs 0 immediately, state IDLE, orphan response ignored; next lw proceeds normally.
